// File: rtl/crossy_robbers_soc_hex_display_ctrl.sv
// Avalon-MM N-digit hex display controller: digit/mask registers, BCD ripple adder, blink prescaler.
// Optional leading-zero blanking (CTRL bit0) is compiled in when CROSSY_HEX_LZB_EN is defined.
module crossy_robbers_soc_hex_display_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_W      = 24,
  parameter int DIV_RESET  = 12500000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [4*NUM_DIGITS-1:0] out_port,
  output logic [7*NUM_DIGITS-1:0] seg_n
);

  localparam int DW    = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RESET);

  // state  | meaning
  // S_IDLE | no add in progress
  // S_ADD  | rippling carry into digit idx, one digit per cycle
  typedef enum logic {S_IDLE, S_ADD} state_t;

  state_t            state, state_nxt;
  logic [DW-1:0]     data, data_nxt;
  logic [NUM_DIGITS-1:0] blank, blink;
  logic [DIV_W-1:0]  blink_div, div_cnt;
  logic              phase;
  logic [3:0]        carry, carry_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              sat, ovr, sat_set, ovr_set;
  logic              wr, wr_data, wr_blank, wr_blink, wr_div, wr_add, wr_status;
  logic [3:0]        cur_digit;
  logic [4:0]        sum, sum_adj;
  logic [NUM_DIGITS-1:0]   vis;
  logic [7*NUM_DIGITS-1:0] seg_nxt;
  logic              unused_wdata;

  assign wr        = chipselect && !write_n;
  assign wr_data   = wr && (address == 3'd0);
  assign wr_blank  = wr && (address == 3'd1);
  assign wr_blink  = wr && (address == 3'd2);
  assign wr_div    = wr && (address == 3'd3);
  assign wr_add    = wr && (address == 3'd4);
  assign wr_status = wr && (address == 3'd5);
  assign unused_wdata = ^writedata;

  assign cur_digit = data[{idx, 2'b00} +: 4];
  assign sum       = {1'b0, cur_digit} + {1'b0, carry};
  assign sum_adj   = sum - 5'd10;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0: seg_decode = 7'h40;
      4'h1: seg_decode = 7'h79;
      4'h2: seg_decode = 7'h24;
      4'h3: seg_decode = 7'h30;
      4'h4: seg_decode = 7'h19;
      4'h5: seg_decode = 7'h12;
      4'h6: seg_decode = 7'h02;
      4'h7: seg_decode = 7'h78;
      4'h8: seg_decode = 7'h00;
      4'h9: seg_decode = 7'h10;
      4'hA: seg_decode = 7'h08;
      4'hB: seg_decode = 7'h03;
      4'hC: seg_decode = 7'h46;
      4'hD: seg_decode = 7'h21;
      4'hE: seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    data_nxt  = data;
    carry_nxt = carry;
    idx_nxt   = idx;
    sat_set   = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (wr_add) begin
          carry_nxt = (writedata[3:0] > 4'd9) ? 4'd9 : writedata[3:0];
          idx_nxt   = '0;
          state_nxt = S_ADD;
        end
      end
      S_ADD: begin
        if (wr_add) ovr_set = 1'b1;
        if (sum > 5'd9) begin
          data_nxt[{idx, 2'b00} +: 4] = sum_adj[3:0];
          carry_nxt = 4'd1;
        end else begin
          data_nxt[{idx, 2'b00} +: 4] = sum[3:0];
          carry_nxt = 4'd0;
        end
        idx_nxt = idx + IDX_W'(1);
        if (sum > 5'd9 && idx == LAST_IDX) begin
          data_nxt  = {NUM_DIGITS{4'h9}};
          sat_set   = 1'b1;
          state_nxt = S_IDLE;
        end else if (sum <= 5'd9 || idx == LAST_IDX) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // A bus write to DATA overrides any add in flight.
    if (wr_data) begin
      data_nxt  = writedata[DW-1:0];
      state_nxt = S_IDLE;
      sat_set   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      data  <= '0;
      carry <= '0;
      idx   <= '0;
      sat   <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      state <= state_nxt;
      data  <= data_nxt;
      carry <= carry_nxt;
      idx   <= idx_nxt;
      if (sat_set) sat <= 1'b1;
      else if (wr_status && writedata[1]) sat <= 1'b0;
      if (ovr_set) ovr <= 1'b1;
      else if (wr_status && writedata[2]) ovr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blank     <= '0;
      blink     <= '0;
      blink_div <= DIV_INIT;
      div_cnt   <= DIV_INIT;
      phase     <= 1'b0;
    end else begin
      if (wr_blank) blank <= writedata[NUM_DIGITS-1:0];
      if (wr_blink) blink <= writedata[NUM_DIGITS-1:0];
      if (wr_div) blink_div <= writedata[DIV_W-1:0];
      if (wr_div) begin
        div_cnt <= writedata[DIV_W-1:0];
        phase   <= 1'b0;
      end else if (blink_div == '0) begin
        div_cnt <= '0;
        phase   <= 1'b0;
      end else if (div_cnt == '0) begin
        div_cnt <= blink_div;
        phase   <= ~phase;
      end else begin
        div_cnt <= div_cnt - DIV_W'(1);
      end
    end
  end

`ifdef CROSSY_HEX_LZB_EN
  logic lzb_en;
  logic nz_above;

  always_ff @(posedge clk) begin
    if (!reset_n) lzb_en <= 1'b0;
    else if (wr && address == 3'd6) lzb_en <= writedata[0];
  end
`endif

  always_comb begin
    vis     = '0;
    seg_nxt = '0;
`ifdef CROSSY_HEX_LZB_EN
    nz_above = 1'b0;
`endif
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      vis[i] = !blank[i] && !(blink[i] && phase);
`ifdef CROSSY_HEX_LZB_EN
      // Walking down from the top digit: dark until the first nonzero digit.
      nz_above = nz_above | (data[4*i +: 4] != 4'h0);
      if (lzb_en && !nz_above && i != 0) vis[i] = 1'b0;
`endif
      seg_nxt[7*i +: 7] = vis[i] ? seg_decode(data[4*i +: 4]) : 7'h7F;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) seg_n <= {NUM_DIGITS{7'h40}};
    else          seg_n <= seg_nxt;
  end

  assign out_port = data;

  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata[DW-1:0]         = data;
      3'd1: readdata[NUM_DIGITS-1:0] = blank;
      3'd2: readdata[NUM_DIGITS-1:0] = blink;
      3'd3: readdata[DIV_W-1:0]      = blink_div;
      3'd5: readdata[2:0]            = {ovr, sat, state == S_ADD};
`ifdef CROSSY_HEX_LZB_EN
      3'd6: readdata[0]              = lzb_en;
`endif
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_crossy_robbers_soc_hex_display_ctrl.sv
// Randomized self-checking bench for the hex display controller against a digit-level model.
module tb_crossy_robbers_soc_hex_display_ctrl;
  localparam int N         = 4;
  localparam int DIV_RESET = 12500000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [4*N-1:0] out_port;
  logic [7*N-1:0] seg_n;

  int n_checks = 0;
  int n_fail   = 0;
  bit m_lzb    = 1'b0;

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  crossy_robbers_soc_hex_display_ctrl #(
    .NUM_DIGITS(N), .DIV_W(24), .DIV_RESET(DIV_RESET)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .seg_n(seg_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = readdata;
  endtask

  // Counts cycles the busy flag is observed high, bounded so a stuck FSM cannot hang the run.
  task automatic wait_idle(output int cnt);
    logic [31:0] v;
    cnt = 0;
    for (int k = 0; k < N + 3; k++) begin
      bus_rd(3'd5, v);
      if (!v[0]) break;
      cnt++;
      tick();
    end
  endtask

  function automatic void bcd_model(input logic [4*N-1:0] d, input int addend,
                                    output logic [4*N-1:0] r, output int cyc, output bit sat);
    int c;
    int s;
    c = (addend > 9) ? 9 : addend;
    r = d; cyc = 0; sat = 1'b0;
    for (int i = 0; i < N; i++) begin
      s = int'(r[4*i +: 4]) + c;
      cyc++;
      if (s > 9) begin r[4*i +: 4] = 4'(s - 10); c = 1; end
      else       begin r[4*i +: 4] = 4'(s);      c = 0; end
      if (c == 0) break;
    end
    if (c != 0) begin
      r = {N{4'h9}};
      sat = 1'b1;
    end
  endfunction

  function automatic logic [7*N-1:0] exp_seg(input logic [4*N-1:0] d, input logic [N-1:0] bl,
                                             input logic [N-1:0] bk, input int ph, input bit lz);
    logic [7*N-1:0] s;
    bit on;
    int dv;
    dv = int'(d);
    s = '0;
    for (int i = 0; i < N; i++) begin
      on = !bl[i] && !(bk[i] && (ph != 0));
      if (lz && i > 0 && (dv >> (4*i)) == 0) on = 1'b0;
      s[7*i +: 7] = on ? dec_tab[d[4*i +: 4]] : 7'h7F;
    end
    return s;
  endfunction

  task automatic do_add(input logic [4*N-1:0] d, input logic [3:0] a);
    logic [4*N-1:0] r;
    logic [31:0] v;
    int cyc, cnt;
    bit s;
    bcd_model(d, int'(a), r, cyc, s);
    bus_wr(3'd0, 32'(d));
    bus_wr(3'd5, 32'h6);
    bus_wr(3'd4, 32'(a));
    wait_idle(cnt);
    chk("add_cycles", 64'(cnt), 64'(cyc));
    chk("add_data", 64'(out_port), 64'(r));
    bus_rd(3'd5, v);
    chk("add_sat", 64'(v[1]), 64'(s));
    chk("add_ovr", 64'(v[2]), 64'(0));
    tick();
    chk("add_seg", 64'(seg_n), 64'(exp_seg(r, '0, '0, 0, m_lzb)));
  endtask

  task automatic blink_run(input logic [4*N-1:0] d, input logic [N-1:0] bl,
                           input logic [N-1:0] bk, input int dv);
    bus_wr(3'd0, 32'(d));
    bus_wr(3'd1, 32'(bl));
    bus_wr(3'd2, 32'(bk));
    bus_wr(3'd3, 32'(dv));
    for (int k = 1; k <= 4 * (dv + 1); k++) begin
      tick();
      chk("blink_seg", 64'(seg_n), 64'(exp_seg(d, bl, bk, ((k - 1) / (dv + 1)) % 2, m_lzb)));
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [4*N-1:0] rd_d;
    logic [31:0] rnd;
    int cnt;

    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    chk("rst_out_port", 64'(out_port), 64'(0));
    chk("rst_seg", 64'(seg_n), 64'({N{7'h40}}));
    bus_rd(3'd5, v); chk("rst_status", 64'(v), 64'(0));
    bus_rd(3'd3, v); chk("rst_div", 64'(v), 64'(DIV_RESET));
    bus_rd(3'd0, v); chk("rst_data", 64'(v), 64'(0));

    bus_wr(3'd0, 32'h1A2F);
    chk("data_out_port", 64'(out_port), 64'h1A2F);
    tick();
    chk("data_seg", 64'(seg_n), 64'({7'h79, 7'h08, 7'h24, 7'h0E}));
    bus_rd(3'd4, v); chk("bcd_add_reads0", 64'(v), 64'(0));
    bus_wr(3'd7, 32'hFFFF_FFFF);
    bus_rd(3'd7, v); chk("rsvd_reads0", 64'(v), 64'(0));
    bus_rd(3'd0, v); chk("rsvd_no_effect", 64'(v), 64'h1A2F);
`ifndef CROSSY_HEX_LZB_EN
    bus_wr(3'd6, 32'h1);
    bus_rd(3'd6, v); chk("ctrl_reads0", 64'(v), 64'(0));
`endif

    do_add(16'h0999, 4'd3);
    chk("add_0999_3", 64'(out_port), 64'h1002);
    do_add(16'h9999, 4'd1);
    chk("add_9999_1", 64'(out_port), 64'h9999);
    do_add(16'h1234, 4'd0);
    do_add(16'h0005, 4'd15);

    for (int it = 0; it < 30; it++) begin
      rnd = $urandom();
      if (it % 5 == 0) rd_d = rnd[4*N-1:0];
      else begin
        for (int i = 0; i < N; i++) rd_d[4*i +: 4] = 4'($urandom_range(0, 9));
        if (it % 7 == 3) rd_d = {N{4'h9}};
      end
      do_add(rd_d, 4'($urandom_range(0, 15)));
    end

    bus_wr(3'd0, 32'h0999);
    bus_wr(3'd5, 32'h6);
    bus_wr(3'd4, 32'h3);
    bus_wr(3'd4, 32'h5);
    wait_idle(cnt);
    chk("ovr_data", 64'(out_port), 64'h1002);
    bus_rd(3'd5, v); chk("ovr_set", 64'(v[2]), 64'(1));
    bus_wr(3'd5, 32'h6);
    bus_rd(3'd5, v); chk("status_clear", 64'(v), 64'(0));

    bus_wr(3'd0, 32'h0999);
    bus_wr(3'd4, 32'h3);
    bus_wr(3'd0, 32'h1234);
    chk("wr_wins_data", 64'(out_port), 64'h1234);
    bus_rd(3'd5, v); chk("wr_wins_idle", 64'(v[0]), 64'(0));
    repeat (3) tick();
    chk("wr_wins_hold", 64'(out_port), 64'h1234);

    bus_wr(3'd0, 32'h9999);
    bus_wr(3'd5, 32'h6);
    bus_wr(3'd4, 32'h1);
    repeat (3) tick();
    bus_wr(3'd5, 32'h6);
    bus_rd(3'd5, v); chk("sat_set_wins", 64'(v[1]), 64'(1));
    bus_wr(3'd5, 32'h6);

    bus_wr(3'd0, 32'h1A2F);
    bus_wr(3'd1, 32'h2);
    bus_wr(3'd2, 32'h1);
    bus_wr(3'd3, 32'h3);
    bus_rd(3'd3, v); chk("div_readback", 64'(v), 64'(3));
    for (int k = 1; k <= 24; k++) begin
      if (k > 1) tick();
      else begin
        @(posedge clk); #1;
      end
      chk("blink_dir", 64'(seg_n), 64'(exp_seg(16'h1A2F, 4'h2, 4'h1, ((k - 1) / 4) % 2, m_lzb)));
      chk("blank_dig1", 64'(seg_n[13:7]), 64'h7F);
    end
    bus_wr(3'd3, 32'h0);
    tick();
    for (int k = 0; k < 10; k++) begin
      chk("div0_steady", 64'(seg_n[6:0]), 64'h0E);
      tick();
    end

    for (int it = 0; it < 6; it++) begin
      rnd = $urandom();
      blink_run(rnd[4*N-1:0], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                $urandom_range(1, 6));
    end

`ifdef CROSSY_HEX_LZB_EN
    bus_wr(3'd3, 32'h0);
    bus_wr(3'd1, 32'h0);
    bus_wr(3'd2, 32'h0);
    bus_wr(3'd6, 32'h1);
    m_lzb = 1'b1;
    bus_rd(3'd6, v); chk("ctrl_readback", 64'(v), 64'(1));
    bus_wr(3'd0, 32'h0040);
    tick();
    chk("lzb_0040", 64'(seg_n), 64'({7'h7F, 7'h7F, 7'h19, 7'h40}));
    bus_wr(3'd0, 32'h0);
    tick();
    chk("lzb_zero", 64'(seg_n), 64'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
    for (int it = 0; it < 4; it++) begin
      rnd = $urandom();
      rd_d = rnd[4*N-1:0] >> (4 * (it % N));
      blink_run(rd_d, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom_range(1, 4));
    end
`endif

    bus_wr(3'd0, 32'h0999);
    bus_wr(3'd4, 32'h3);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midrst_out_port", 64'(out_port), 64'(0));
    chk("midrst_seg", 64'(seg_n), 64'({N{7'h40}}));
    bus_rd(3'd5, v); chk("midrst_status", 64'(v), 64'(0));
    bus_rd(3'd3, v); chk("midrst_div", 64'(v), 64'(DIV_RESET));
    bus_rd(3'd2, v); chk("midrst_blink", 64'(v), 64'(0));
    bus_rd(3'd6, v); chk("midrst_ctrl", 64'(v), 64'(0));
    repeat (3) tick();
    chk("midrst_hold", 64'(out_port), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crossy_robbers_soc_hex_display_ctrl.md
Name: crossy_robbers_soc_hex_display_ctrl

Overview:
- Parametrised Avalon-MM successor to the fixed 16-bit hex-digit output PIO.
- Holds N BCD/hex digits and applies per-digit blank and blink masks.
- Performs hardware BCD score increments with a carry-ripple FSM, one digit per cycle.
- Drives registered active-low 7-segment outputs plus a raw nibble port. Sits on the Nios II data bus and feeds the board HEX displays.

Parameters:
- NUM_DIGITS, 4: number of 4-bit digits; legal range 1..8.
- DIV_W, 24: width of the blink prescaler.
- DIV_RESET, 12500000: reset value of BLINK_DIV (4 Hz toggle at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset, sampled on rising clk.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data; zero wait states; readLatency 0.
- out_port  out  4*NUM_DIGITS  raw DATA register.
- seg_n  out  7*NUM_DIGITS  per-digit segments {g..a}, active low; digit i at [7i+6:7i].

Behaviour:
- Reset and clocking: one clock domain. Reset is synchronous and active-low.
- Reset values: DATA=0, BLANK=0, BLINK=0, BLINK_DIV=DIV_RESET, prescaler=DIV_RESET, phase=0, FSM=IDLE, STATUS=0, out_port=0, seg_n=7'h40 per digit.
- Writes: a write is chipselect && !write_n. It takes effect at the same rising edge.
- Reads: readdata is combinational from address. Unused high bits read 0.
- Register map:
  - 0 DATA: RW, [4N-1:0].
  - 1 BLANK: RW, [N-1:0]; 1 = digit dark.
  - 2 BLINK: RW, [N-1:0]; 1 = digit blinks.
  - 3 BLINK_DIV: RW, [DIV_W-1:0].
  - 4 BCD_ADD: WO; reads 0.
  - 5 STATUS: bit0 busy (RO), bit1 sat (sticky), bit2 ovr (sticky). Writing 1 to bit1/bit2 clears that bit.
  - 6 CTRL: see optional feature.
  - 7: reserved; reads 0, writes ignored.
- BCD FSM, states IDLE and ADD:
  - A BCD_ADD write in IDLE latches carry = min(writedata[3:0], 9) and idx = 0, then enters ADD. busy=1 from the next cycle.
  - In ADD, each edge does: sum = DATA[idx] + carry (5 bit). If sum > 9, DATA[idx] = sum - 10 and carry = 1; otherwise DATA[idx] = sum and carry = 0. Then idx increments.
  - Exit to IDLE when carry becomes 0 or after idx = N-1.
  - Carry out of digit N-1: set all digits to 9 and set sat.
  - Latency: the add is done 1..N cycles after the write edge. An addend of 0 still takes 1 cycle.
- Collisions:
  - BCD_ADD write while busy: dropped; ovr set.
  - DATA write while busy: write wins; FSM returns to IDLE at that edge.
  - STATUS clear coinciding with sat/ovr set: set wins.
- Blink prescaler:
  - If BLINK_DIV=0: phase held 0 and counter held 0.
  - Otherwise the counter decrements each cycle. At 0 it reloads BLINK_DIV and phase toggles (period 2*(BLINK_DIV+1) cycles).
  - A BLINK_DIV write reloads the counter with the new value and clears phase.
- Display:
  - vis[i] = !BLANK[i] && !(BLINK[i] && phase).
  - seg_n digit = vis ? decode(DATA[i]) : 7'h7F.
  - seg_n is registered: 1 cycle after any DATA/mask/phase change.
- Decode table (hex):
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
- out_port = DATA; no extra latency.
- Reset mid-operation: FSM aborts and all state returns to reset values.

Optional Feature:
- Macro: CROSSY_HEX_LZB_EN.
- Defined: CTRL bit0 (RW, reset 0) enables leading-zero blanking.
  - Digits above the most significant nonzero digit are forced dark. Digit 0 is never blanked by this feature.
  - Applied in the same seg_n register stage; combines with BLANK/BLINK by AND of visibility.
- Undefined: CTRL reads 0, writes are ignored, no LZB logic is present.

Test Plan:
- Reset: hold reset_n=0 3 cycles -> out_port=0, seg_n=0x40 per digit, STATUS=0, readdata(3)=DIV_RESET.
- Write DATA=0x1A2F -> out_port=0x1A2F next edge; one cycle later seg_n digits {3..0} = {79,08,24,0E}.
- DATA=0x0999, BCD_ADD=3 -> busy for 4 cycles; DATA=0x1002, sat=0. DATA=0x9999, BCD_ADD=1 -> DATA=0x9999, sat=1.
- BCD_ADD during busy -> ovr=1 and DATA unaffected by the 2nd addend. DATA write during busy -> DATA equals written value, busy=0 next cycle.
- BLINK_DIV=3, BLINK=0x1, BLANK=0x2 -> digit1 always 7F; digit0 alternates every 4 cycles; BLINK_DIV=0 -> digit0 steady.
- With CROSSY_HEX_LZB_EN, CTRL=1, DATA=0x0040 -> digits 3,2 dark, digit1=0x19, digit0=0x40. DATA=0 -> only digit0 lit.
